// File: rtl/led_seq_ctrl_if.sv
// Command bus of the LED sequencer: valid/ready command handshake plus abort.
//   cmd_valid  : command offered (master -> slave)
//   cmd_ready  : sequencer idle and able to take a command (slave -> master)
//   cmd_mode   : 00 rotate-left, 01 rotate-right, 10 blink-all, 11 bounce
//   cmd_period : clocks per step (0 behaves as 1)
//   cmd_steps  : number of pattern advances (0 runs until abort)
//   abort      : stop the running sequence
interface led_seq_ctrl_if #(
  parameter int CNT_W  = 25,
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [CNT_W-1:0]  cmd_period;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;

  modport master (
    output cmd_valid, cmd_mode, cmd_period, cmd_steps, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_period, cmd_steps, abort,
    output cmd_ready
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// Command-driven sequencer for the LED bank. Takes one pattern command at a
// time, steps the pattern every 'period' clocks for 'steps' advances (or until
// abort when steps is 0) and pulses done when a finite sequence completes.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : command handshake + abort (slave side of led_seq_ctrl_if)
//   led  : LED drive, 1 = on
//   busy : high while running or in the completion cycle
//   done : one-cycle pulse when a finite sequence completes
module led_seq_ctrl #(
  parameter int CNT_W  = 25,
  parameter int STEP_W = 8,
  parameter int LED_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_seq_ctrl_if.slave     bus,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_ROL    = 2'b00;
  localparam logic [1:0] M_ROR    = 2'b01;
  localparam logic [1:0] M_BLINK  = 2'b10;
  localparam logic [1:0] M_BOUNCE = 2'b11;

  logic [1:0]        state;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  period_q;
  logic [STEP_W-1:0] steps_q;
  logic [CNT_W-1:0]  tick_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_nxt;
  logic              dir_up;
  logic              dir_nxt;
  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  led_nxt;
  logic [LED_W-1:0]  start_pat;
  logic              tick_wrap;

  assign step_nxt  = step_cnt + STEP_W'(1);
  assign tick_wrap = (tick_cnt == period_q - CNT_W'(1));

  // Start pattern for the command currently offered on the bus.
  always_comb begin
    start_pat = '0;
    case (bus.cmd_mode)
      M_ROL:    start_pat = LED_W'(1);
      M_ROR:    start_pat = {1'b1, {(LED_W-1){1'b0}}};
      M_BLINK:  start_pat = '1;
      M_BOUNCE: start_pat = LED_W'(1);
      default:  start_pat = '0;
    endcase
  end

  // Next pattern for one advance. Bounce flips direction on reaching an end
  // so the end positions are shown once each turn.
  always_comb begin
    led_nxt = led_q;
    dir_nxt = dir_up;
    case (mode_q)
      M_ROL:   led_nxt = {led_q[LED_W-2:0], led_q[LED_W-1]};
      M_ROR:   led_nxt = {led_q[0], led_q[LED_W-1:1]};
      M_BLINK: led_nxt = ~led_q;
      M_BOUNCE: begin
        if (dir_up) begin
          led_nxt = led_q << 1;
          if (led_nxt[LED_W-1]) dir_nxt = 1'b0;
        end else begin
          led_nxt = led_q >> 1;
          if (led_nxt[0]) dir_nxt = 1'b1;
        end
      end
      default: led_nxt = led_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      period_q <= '0;
      steps_q  <= '0;
      tick_cnt <= '0;
      step_cnt <= '0;
      dir_up   <= 1'b0;
      led_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state    <= S_RUN;
            mode_q   <= bus.cmd_mode;
            period_q <= (bus.cmd_period == '0) ? CNT_W'(1) : bus.cmd_period;
            steps_q  <= bus.cmd_steps;
            tick_cnt <= '0;
            step_cnt <= '0;
            dir_up   <= 1'b1;
            led_q    <= start_pat;
          end
        end
        S_RUN: begin
          // Abort takes priority over an advance on the same edge.
          if (bus.abort) begin
            state <= S_IDLE;
            led_q <= '0;
          end else if (tick_wrap) begin
            tick_cnt <= '0;
            step_cnt <= step_nxt;
            led_q    <= led_nxt;
            dir_up   <= dir_nxt;
            if (steps_q != '0 && step_nxt == steps_q) state <= S_DONE;
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign busy          = (state == S_RUN) || (state == S_DONE);
  assign done          = (state == S_DONE);
  assign led           = led_q;

endmodule
